// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: pairs 4-bit LCD write-bus nibbles into bytes, decodes the
// HD44780 write subset and keeps a 2-line shadow of the visible DDRAM.
module lcd_bus_receiver #(
   parameter int LINE_LEN = 16
) (
   input  logic       SLOW_CLK,
   input  logic       SYS_RST_N,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic       LCD_E,
   input  logic [7:4] LCD_DATA,
   output logic       BYTE_VALID,
   output logic       BYTE_RS,
   output logic [7:0] BYTE_DATA,
   input  logic [4:0] RD_ADDR,
   output logic [7:0] RD_CHAR,
   output logic [6:0] CURSOR_ADDR,
   output logic [2:0] DISP_CTRL,
   output logic [1:0] ERR_FLAGS
);
   localparam logic [0:0] ST_UPPER = 1'b0;
   localparam logic [0:0] ST_LOWER = 1'b1;
   logic       r_e_q;
   logic       r_rs_q;
   logic [3:0] r_d_q;
   logic [0:0] r_phase;
   logic [3:0] r_hi;
   logic       r_hrs;
   logic [6:0] r_ac;
   logic       r_id;
   logic [2:0] r_disp;
   logic [1:0] r_err;
   logic       r_byte_valid;
   logic       r_byte_rs;
   logic [7:0] r_byte_data;
   logic [2*LINE_LEN-1:0] r_valid;
   logic [7:0] r_shadow [0:2*LINE_LEN-1];
   logic       w_strobe;
   logic       w_take;
   logic       w_byte_ok;
   logic [7:0] w_byte;
   logic       w_vis;
   logic [4:0] w_widx;
   logic [6:0] w_ac_nxt;
   logic       w_id_nxt;
   logic [2:0] w_disp_nxt;
   logic       w_clear;
   logic       w_wr;
   // DDRAM counter walks 0x00..0x27 then 0x40..0x67 as one 80-entry ring
   function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
      if (inc) return a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1;
      return a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1;
   endfunction
   assign w_strobe  = r_e_q & ~LCD_E;
   assign w_take    = w_strobe & ~LCD_RW;
   assign w_byte_ok = w_take & (r_phase == ST_LOWER) & (r_rs_q == r_hrs);
   assign w_byte    = {r_hi, r_d_q};
   assign w_vis     = r_ac[5:0] < 6'(LINE_LEN);
   assign w_widx    = {r_ac[6], r_ac[3:0]};
   always_comb begin
      w_ac_nxt   = r_ac;
      w_id_nxt   = r_id;
      w_disp_nxt = r_disp;
      w_clear    = 1'b0;
      w_wr       = 1'b0;
      if (w_byte_ok) begin
         if (r_hrs) begin
            w_wr     = w_vis;
            w_ac_nxt = f_step(r_ac, r_id);
         end else if (w_byte[7]) begin
            w_ac_nxt = w_byte[6:0];
         end else if (w_byte[6:5] == 2'b00) begin
            if (w_byte[4]) begin
               w_ac_nxt = w_byte[3] ? r_ac : f_step(r_ac, w_byte[2]);
            end else if (w_byte[3]) begin
               w_disp_nxt = w_byte[2:0];
            end else if (w_byte[2]) begin
               w_id_nxt = w_byte[1];
            end else if (w_byte[1]) begin
               w_ac_nxt = 7'h00;
            end else if (w_byte[0]) begin
               w_clear  = 1'b1;
               w_ac_nxt = 7'h00;
               w_id_nxt = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge SLOW_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         r_e_q        <= 1'b0;
         r_rs_q       <= 1'b0;
         r_d_q        <= 4'h0;
         r_phase      <= ST_UPPER;
         r_hi         <= 4'h0;
         r_hrs        <= 1'b0;
         r_ac         <= 7'h00;
         r_id         <= 1'b1;
         r_disp       <= 3'b000;
         r_err        <= 2'b00;
         r_byte_valid <= 1'b0;
         r_byte_rs    <= 1'b0;
         r_byte_data  <= 8'h00;
         r_valid      <= '0;
      end else begin
         r_e_q <= LCD_E;
         if (LCD_E) begin
            r_d_q  <= LCD_DATA;
            r_rs_q <= LCD_RS;
         end
         if (w_take) begin
            if (r_phase == ST_UPPER) begin
               r_hi    <= r_d_q;
               r_hrs   <= r_rs_q;
               r_phase <= ST_LOWER;
            end else begin
               r_phase <= ST_UPPER;
               if (r_rs_q != r_hrs) r_err[1] <= 1'b1;
            end
         end
         if (w_strobe & LCD_RW) r_err[0] <= 1'b1;
         r_byte_valid <= w_byte_ok;
         if (w_byte_ok) begin
            r_byte_rs   <= r_hrs;
            r_byte_data <= w_byte;
         end
         r_ac   <= w_ac_nxt;
         r_id   <= w_id_nxt;
         r_disp <= w_disp_nxt;
         if (w_clear) r_valid <= '0;
         else if (w_wr) r_valid[w_widx] <= 1'b1;
      end
   end
   always_ff @(posedge SLOW_CLK) begin
      if (w_wr) r_shadow[w_widx] <= w_byte;
   end
   assign RD_CHAR     = r_valid[RD_ADDR] ? r_shadow[RD_ADDR] : 8'h20;
   assign BYTE_VALID  = r_byte_valid;
   assign BYTE_RS     = r_byte_rs;
   assign BYTE_DATA   = r_byte_data;
   assign CURSOR_ADDR = r_ac;
   assign DISP_CTRL   = r_disp;
   assign ERR_FLAGS   = r_err;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: random and directed LCD bus traffic checked against a
// DDRAM-level reference model through an expected-byte scoreboard.
`timescale 1ns/1ps
module tb_lcd_bus_receiver;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rs = 1'b0;
   logic       rw = 1'b0;
   logic       e = 1'b0;
   logic [7:4] data = 4'h0;
   logic [4:0] rd_addr = 5'd0;
   logic       byte_valid;
   logic       byte_rs;
   logic [7:0] byte_data;
   logic [7:0] rd_char;
   logic [6:0] cursor_addr;
   logic [2:0] disp_ctrl;
   logic [1:0] err_flags;
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
      logic [6:0] ac;
   } exp_t;
   exp_t q[$];
   exp_t mon_x;
   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] m_ch [128];
   bit         m_v  [128];
   logic [6:0] m_ac;
   bit         m_id;
   logic [2:0] m_disp;
   logic [1:0] m_err;
   always #5 clk = ~clk;
   lcd_bus_receiver #(.LINE_LEN(16)) dut (
      .SLOW_CLK(clk), .SYS_RST_N(rst_n), .LCD_RS(rs), .LCD_RW(rw), .LCD_E(e),
      .LCD_DATA(data), .BYTE_VALID(byte_valid), .BYTE_RS(byte_rs),
      .BYTE_DATA(byte_data), .RD_ADDR(rd_addr), .RD_CHAR(rd_char),
      .CURSOR_ADDR(cursor_addr), .DISP_CTRL(disp_ctrl), .ERR_FLAGS(err_flags)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // DDRAM positions as a flat 80-character ring: line 1 is 0..39, line 2 is 40..79
   function automatic int a2p(input logic [6:0] a);
      return a < 7'h40 ? int'(a) : int'(a) - 'h40 + 40;
   endfunction
   function automatic logic [6:0] p2a(input int p);
      return p < 40 ? 7'(p) : 7'(p - 40 + 'h40);
   endfunction
   function automatic logic [6:0] m_step(input logic [6:0] a, input bit inc);
      return p2a((a2p(a) + (inc ? 1 : 79)) % 80);
   endfunction
   task automatic m_reset();
      m_v = '{default: 0};
      m_ac = 7'h00;
      m_id = 1'b1;
      m_disp = 3'b000;
      m_err = 2'b00;
   endtask
   task automatic m_byte(input bit brs, input logic [7:0] b);
      if (brs) begin
         if (m_ac < 7'h10 || (m_ac >= 7'h40 && m_ac < 7'h50)) begin
            m_ch[m_ac] = b;
            m_v[m_ac] = 1'b1;
         end
         m_ac = m_step(m_ac, m_id);
      end else if (b >= 8'h80) m_ac = b[6:0];
      else if (b >= 8'h20) m_ac = m_ac;
      else if (b >= 8'h10) begin
         if (!b[3]) m_ac = m_step(m_ac, b[2]);
      end else if (b >= 8'h08) m_disp = b[2:0];
      else if (b >= 8'h04) m_id = b[1];
      else if (b >= 8'h02) m_ac = 7'h00;
      else if (b == 8'h01) begin
         m_v = '{default: 0};
         m_ac = 7'h00;
         m_id = 1'b1;
      end
      q.push_back({brs, b, m_ac});
   endtask
   task automatic send_nib(input bit nrs, input logic [3:0] nib, input bit nrw, input int hold);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         e = 1'b1; rs = 1'($urandom); rw = 1'($urandom); data = 4'($urandom);
      end
      @(posedge clk); #1;
      e = 1'b1; rs = nrs; rw = nrw; data = nib;
      @(posedge clk); #1;
      e = 1'b0;
   endtask
   task automatic send_byte(input bit brs, input logic [7:0] b, input int hold = 1);
      m_byte(brs, b);
      send_nib(brs, b[7:4], 1'b0, hold);
      send_nib(brs, b[3:0], 1'b0, hold);
   endtask
   task automatic check_state(input string tag);
      logic [6:0] a;
      repeat (3) @(posedge clk);
      #1;
      for (int r = 0; r < 32; r++) begin
         rd_addr = 5'(r);
         a = r >= 16 ? 7'(r - 16 + 'h40) : 7'(r);
         #1;
         chk($sformatf("%s rd_char[%0d]", tag, r), rd_char, m_v[a] ? m_ch[a] : 8'h20);
      end
      chk({tag, " cursor"}, cursor_addr, m_ac);
      chk({tag, " disp"}, disp_ctrl, m_disp);
      chk({tag, " err"}, err_flags, m_err);
   endtask
   always @(negedge clk) begin
      if (byte_valid === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got rs=%0b data=%0h expected none", byte_rs, byte_data);
         end else begin
            mon_x = q.pop_front();
            chk("byte_rs", byte_rs, mon_x.rs);
            chk("byte_data", byte_data, mon_x.data);
            chk("byte_cursor", cursor_addr, mon_x.ac);
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] b;
      string txt;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset byte_valid", byte_valid, 1'b0);
      chk("reset byte_rs", byte_rs, 1'b0);
      chk("reset byte_data", byte_data, 8'h00);
      rst_n = 1'b1;
      check_state("reset");
      send_byte(0, 8'h01); send_byte(0, 8'h06); send_byte(0, 8'h0C); send_byte(0, 8'h28);
      check_state("init");
      chk("init disp const", disp_ctrl, 3'b100);
      txt = "AKSHI";
      for (int i = 0; i < 5; i++) send_byte(1, txt[i]);
      send_byte(1, 8'hA0);
      txt = "TECH";
      for (int i = 0; i < 4; i++) send_byte(1, txt[i]);
      check_state("text");
      chk("text cursor const", cursor_addr, 7'h0A);
      send_byte(0, 8'hC0); send_byte(1, "Z");
      check_state("line2");
      chk("line2 cursor const", cursor_addr, 7'h41);
      send_byte(0, 8'h01);
      check_state("clear");
      send_byte(0, 8'hA7); send_byte(1, "w");
      check_state("wrap27");
      send_byte(0, 8'hE7); send_byte(1, "y");
      check_state("wrap67");
      send_byte(0, 8'h04); send_byte(0, 8'hC0); send_byte(1, "Q");
      check_state("decrement");
      chk("decrement cursor const", cursor_addr, 7'h27);
      send_nib(1, 4'h4, 0, 1); send_nib(0, 4'h1, 0, 1);
      m_err[1] = 1'b1;
      send_byte(1, "X");
      check_state("rs_mismatch");
      m_byte(1, 8'h52);
      send_nib(1, 4'h5, 0, 1); send_nib(0, 4'hF, 1, 1); send_nib(1, 4'h2, 0, 1);
      m_err[0] = 1'b1;
      check_state("rw_strobe");
      send_byte(0, 8'h06, 3);
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: b = 8'($urandom_range(8'h20, 8'h7E));
            5: b = {1'b1, p2a($urandom_range(0, 79))};
            6: b = 8'h04 | 8'($urandom_range(0, 3));
            7: b = 8'h08 | 8'($urandom_range(0, 7));
            8: b = 8'h10 | 8'($urandom_range(0, 15));
            default: b = 8'($urandom_range(0, 2) == 0 ? 8'h01 : $urandom_range(0, 1) ? 8'h03 : 8'h28);
         endcase
         send_byte($urandom_range(0, 9) < 5 && b >= 8'h20 && b < 8'h7F, b, $urandom_range(1, 3));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         if (it % 50 == 49) check_state($sformatf("random%0d", it));
      end
      send_byte(0, 8'h80);
      send_nib(0, 4'h8, 0, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      m_reset();
      q.delete();
      #1;
      chk("midreset byte_valid", byte_valid, 1'b0);
      chk("midreset byte_data", byte_data, 8'h00);
      chk("midreset byte_rs", byte_rs, 1'b0);
      check_state("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_byte(0, 8'h0C);
      send_byte(1, "K");
      check_state("after_reset");
      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
